// File: rtl/decode_immediate_stage.sv
// Decode-stage front end: opcode classification, immediate formation,
// two-entry skid buffer, flush and a decoded-instruction counter.

package decode_immediate_pkg;
    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5
    } inst_type_e;
endpackage

module decode_immediate_stage
    import decode_immediate_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instruction,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instruction,
    output logic [XLEN-1:0]        out_pc,
    output logic [2:0]             out_instruction_type,
    output logic [XLEN-1:0]        out_immediate,
    output logic                   out_illegal,
    output logic [COUNT_WIDTH-1:0] decoded_count
);

    typedef struct packed {
        logic [31:0]     instruction;
        logic [XLEN-1:0] pc;
        logic [2:0]      itype;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    entry_t                 main_q, main_d;
    entry_t                 skid_q, skid_d;
    entry_t                 dec;
    logic                   in_ready_q, in_ready_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   in_fire;
    logic                   out_fire;
    logic [31:0]            ins;

    assign ins      = in_instruction;
    assign in_ready = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire  = in_valid & in_ready_q & ~flush;
    assign out_fire = out_valid & out_ready;

    assign out_instruction      = main_q.instruction;
    assign out_pc               = main_q.pc;
    assign out_instruction_type = main_q.itype;
    assign out_immediate        = main_q.imm;
    assign out_illegal          = main_q.illegal;
    assign decoded_count        = count_q;

    // Classify the incoming opcode and build its sign-extended immediate.
    // Every legal opcode ends in 2'b11, so the default arm also catches
    // compressed/bad low bits.
    always_comb begin
        dec             = '0;
        dec.instruction = ins;
        dec.pc          = in_pc;
        dec.itype       = TYPE_R;
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin
                dec.itype = TYPE_U;
                dec.imm   = {ins[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.itype = TYPE_J;
                dec.imm   = {{(XLEN-21){ins[31]}}, ins[31],
                             ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: begin
                dec.itype = TYPE_I;
                dec.imm   = {{(XLEN-12){ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                dec.itype = TYPE_S;
                dec.imm   = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                dec.itype = TYPE_B;
                dec.imm   = {{(XLEN-13){ins[31]}}, ins[31], ins[7],
                             ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110011: begin
                dec.itype = TYPE_R;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Skid-buffer occupancy, entry movement, flush and counter update.
    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        in_ready_d = in_ready_q;
        count_d    = count_q;
        if (out_fire) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = dec;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = dec;
                end else if (in_fire) begin
                    skid_d  = dec;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        in_ready_d = (state_d != ST_FULL);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_decode_immediate_stage.sv
// Self-checking bench for decode_immediate_stage: directed table,
// stall/flush/wrap/reset sequences and a randomized queue-model run.

module tb_decode_immediate_stage;
    import decode_immediate_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [2:0]  out_instruction_type;
    logic [31:0] out_immediate;
    logic        out_illegal;
    logic [31:0] decoded_count;

    decode_immediate_stage #(.XLEN(32), .COUNT_WIDTH(32)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .flush               (flush),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_instruction      (in_instruction),
        .in_pc               (in_pc),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_instruction     (out_instruction),
        .out_pc              (out_pc),
        .out_instruction_type(out_instruction_type),
        .out_immediate       (out_immediate),
        .out_illegal         (out_illegal),
        .decoded_count       (decoded_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  t;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  t;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    vec_t        tbl[12];
    exp_t        q[$];
    exp_t        e;
    logic [31:0] exp_cnt;
    logic        fo;
    logic        fi;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode built from field weights with plain arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] i,
                                        input logic [31:0] pc);
        exp_t r;
        r.inst = i;
        r.pc   = pc;
        r.t    = TYPE_R;
        r.imm  = 32'd0;
        r.ill  = 1'b0;
        case (i[6:0])
            7'b0110111, 7'b0010111: begin
                r.t   = TYPE_U;
                r.imm = i & 32'hFFFF_F000;
            end
            7'b1101111: begin
                r.t   = TYPE_J;
                r.imm = 32'(i[19:12]) * 4096 + 32'(i[20]) * 2048
                      + 32'(i[30:21]) * 2
                      - (i[31] ? 32'd1048576 : 32'd0);
            end
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: begin
                r.t   = TYPE_I;
                r.imm = 32'(i[31:20]) - (i[31] ? 32'd4096 : 32'd0);
            end
            7'b0100011: begin
                r.t   = TYPE_S;
                r.imm = 32'(i[31:25]) * 32 + 32'(i[11:7])
                      - (i[31] ? 32'd4096 : 32'd0);
            end
            7'b1100011: begin
                r.t   = TYPE_B;
                r.imm = 32'(i[11:8]) * 2 + 32'(i[30:25]) * 32
                      + 32'(i[7]) * 2048
                      - (i[31] ? 32'd4096 : 32'd0);
            end
            7'b0110011: r.t = TYPE_R;
            default:    r.ill = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 9))
                0: w[6:0] = 7'b0110111;
                1: w[6:0] = 7'b0010111;
                2: w[6:0] = 7'b1101111;
                3: w[6:0] = 7'b1100111;
                4: w[6:0] = 7'b0000011;
                5: w[6:0] = 7'b0010011;
                6: w[6:0] = 7'b0100011;
                7: w[6:0] = 7'b1100011;
                8: w[6:0] = 7'b0110011;
                default: w[6:0] = 7'b1110011;
            endcase
        end
        return w;
    endfunction

    task automatic send(input logic [31:0] i, input logic [31:0] pc);
        in_valid       = 1'b1;
        in_instruction = i;
        in_pc          = pc;
    endtask

    initial begin
        tbl[0]  = '{32'hFFF00093, TYPE_I, 32'hFFFFFFFF, 1'b0};
        tbl[1]  = '{32'h00112623, TYPE_S, 32'h0000000C, 1'b0};
        tbl[2]  = '{32'hFE000EE3, TYPE_B, 32'hFFFFFFFC, 1'b0};
        tbl[3]  = '{32'h123452B7, TYPE_U, 32'h12345000, 1'b0};
        tbl[4]  = '{32'h008000EF, TYPE_J, 32'h00000008, 1'b0};
        tbl[5]  = '{32'hFFDFF0EF, TYPE_J, 32'hFFFFFFFC, 1'b0};
        tbl[6]  = '{32'h002081B3, TYPE_R, 32'h00000000, 1'b0};
        tbl[7]  = '{32'h00000000, TYPE_R, 32'h00000000, 1'b1};
        tbl[8]  = '{32'h0000007F, TYPE_R, 32'h00000000, 1'b1};
        tbl[9]  = '{32'h00000012, TYPE_R, 32'h00000000, 1'b1};
        tbl[10] = '{32'hFFFFFFB7, TYPE_U, 32'hFFFFF000, 1'b0};
        tbl[11] = '{32'h8000006F, TYPE_J, 32'hFFF00000, 1'b0};

        reset_n        = 1'b0;
        flush          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        in_instruction = 32'd0;
        in_pc          = 32'd0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_inst", out_instruction, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_type", 32'(out_instruction_type), 32'd0);
        chk("rst_imm", out_immediate, 32'd0);
        chk("rst_ill", 32'(out_illegal), 32'd0);
        chk("rst_count", decoded_count, 32'd0);
        reset_n = 1'b1;

        // Back-to-back table stream with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].inst, 32'h1000 + 32'(i) * 4);
            step();
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_inst", out_instruction, tbl[i].inst);
            chk("tbl_pc", out_pc, 32'h1000 + 32'(i) * 4);
            chk("tbl_type", 32'(out_instruction_type), 32'(tbl[i].t));
            chk("tbl_imm", out_immediate, tbl[i].imm);
            chk("tbl_ill", 32'(out_illegal), 32'(tbl[i].ill));
            chk("tbl_in_ready", 32'(in_ready), 32'd1);
            chk("tbl_count", decoded_count, 32'(i));
        end
        in_valid = 1'b0;
        step();
        chk("tbl_drain_valid", 32'(out_valid), 32'd0);
        chk("tbl_drain_count", decoded_count, 32'd12);
        exp_cnt = 32'd12;

        // Stall: A to main, B to skid, C held off until release.
        out_ready = 1'b0;
        send(32'h00100093, 32'h2000);
        step();
        chk("stall_a_valid", 32'(out_valid), 32'd1);
        chk("stall_a_rdy", 32'(in_ready), 32'd1);
        send(32'h00200113, 32'h2004);
        step();
        chk("stall_full_rdy", 32'(in_ready), 32'd0);
        chk("stall_hold_a", out_instruction, 32'h00100093);
        send(32'h00300193, 32'h2008);
        step();
        chk("stall_hold_a2", out_instruction, 32'h00100093);
        chk("stall_rdy2", 32'(in_ready), 32'd0);
        chk("stall_cnt", decoded_count, exp_cnt);
        out_ready = 1'b1;
        step();
        chk("rel_b", out_instruction, 32'h00200113);
        chk("rel_b_pc", out_pc, 32'h2004);
        chk("rel_rdy", 32'(in_ready), 32'd1);
        step();
        chk("rel_c", out_instruction, 32'h00300193);
        chk("rel_c_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        chk("rel_empty", 32'(out_valid), 32'd0);
        exp_cnt = exp_cnt + 3;
        chk("rel_cnt", decoded_count, exp_cnt);

        // Flush while FULL with a new input offered, no output handshake.
        out_ready = 1'b0;
        send(32'h00400213, 32'h3000);
        step();
        send(32'h00500293, 32'h3004);
        step();
        chk("fl_full_rdy", 32'(in_ready), 32'd0);
        flush = 1'b1;
        send(32'h00600313, 32'h3008);
        step();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_rdy", 32'(in_ready), 32'd1);
        chk("fl_cnt", decoded_count, exp_cnt);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl_stays_empty", 32'(out_valid), 32'd0);
        chk("fl_cnt2", decoded_count, exp_cnt);

        // Flush coinciding with an output handshake still counts it.
        out_ready = 1'b0;
        send(32'h00700393, 32'h4000);
        step();
        flush = 1'b1;
        out_ready = 1'b1;
        send(32'h00800413, 32'h4004);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 1;
        chk("flhs_valid", 32'(out_valid), 32'd0);
        chk("flhs_cnt", decoded_count, exp_cnt);

        // Counter wrap from all-ones.
        force dut.count_q = 32'hFFFFFFFF;
        #1;
        release dut.count_q;
        send(32'h00900493, 32'h5000);
        step();
        in_valid = 1'b0;
        chk("wrap_pre", decoded_count, 32'hFFFFFFFF);
        step();
        chk("wrap_zero", decoded_count, 32'd0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        send(32'h00A00513, 32'h6000);
        step();
        send(32'h00B00593, 32'h6004);
        step();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd1);
        chk("arst_inst", out_instruction, 32'd0);
        chk("arst_imm", out_immediate, 32'd0);
        chk("arst_cnt", decoded_count, 32'd0);
        step();
        reset_n = 1'b1;

        // Randomized run against the queue model.
        exp_cnt = 32'd0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            chk("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_rdy", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                e = q[0];
                chk("rnd_inst", out_instruction, e.inst);
                chk("rnd_pc", out_pc, e.pc);
                chk("rnd_type", 32'(out_instruction_type), 32'(e.t));
                chk("rnd_imm", out_immediate, e.imm);
                chk("rnd_ill", 32'(out_illegal), 32'(e.ill));
            end
            chk("rnd_cnt", decoded_count, exp_cnt);
            in_valid       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            flush          = ($urandom_range(0, 19) == 0);
            in_instruction = rand_inst();
            in_pc          = $urandom;
            fo = (q.size() > 0) && out_ready;
            fi = in_valid && (q.size() < 2) && !flush;
            e  = ref_decode(in_instruction, in_pc);
            step();
            if (fo) begin
                void'(q.pop_front());
                exp_cnt = exp_cnt + 1;
            end
            if (flush) begin
                q.delete();
            end else if (fi) begin
                q.push_back(e);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_immediate_stage.md
Name: decode_immediate_stage

Overview:
- Registered decode-stage front end, between fetch and register-file/execute.
- Accepts 32-bit instructions over a valid/ready handshake and classifies each opcode into an instruction type.
- Forms the sign-extended immediate, flags illegal encodings and presents the result downstream with 1-cycle latency.
- Two-entry skid buffer keeps full throughput under downstream stalls; synchronous flush serves branch/jump redirects; decoded-instruction counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width of pc and immediate (only 32 supported).
- COUNT_WIDTH, 32, width of decoded_count.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept.
- in_instruction  input  32  raw instruction word.
- in_pc  input  XLEN  instruction address.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  downstream accepts.
- out_instruction  output  32  instruction passed through.
- out_pc  output  XLEN  pc passed through.
- out_instruction_type  output  3  type code (R/I/S/B/U/J, shared defines).
- out_immediate  output  XLEN  sign-extended immediate.
- out_illegal  output  1  unsupported opcode or bits[1:0] != 2'b11.
- decoded_count  output  COUNT_WIDTH  number of entries handed downstream.

Behaviour:
- Reset (async assert, sync-release usage): main and skid entries invalid, in_ready=1, out_valid=0, all out_* data=0, decoded_count=0.
- Classification by opcode [6:0]:
  - 0110111 / 0010111 -> U.
  - 1101111 -> J.
  - 1100111 / 0000011 / 0010011 / 0001111 / 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110011 -> R, immediate 0.
  - Anything else, or bits[1:0] != 11 -> type R, immediate 0, out_illegal=1.
- Immediate per RV32I:
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U: {inst[31:12], 12'b0}.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
- Classification and immediate are combinational on the input, then registered. Latency: accepted on edge N -> visible on out_* after edge N, i.e. 1 cycle.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - out_* stable while out_valid & !out_ready.
  - in_ready is registered and equals !skid_valid.
- States:
  - EMPTY (main invalid).
  - ONE (main valid, skid empty).
  - FULL (main and skid valid).
- Transitions:
  - EMPTY + in -> ONE.
  - ONE + in + out -> ONE (main reloaded).
  - ONE + in + !out -> FULL (new entry into skid).
  - ONE + out, no in -> EMPTY.
  - FULL + out -> ONE (skid moves to main; in_ready=0 during FULL, so no input that cycle).
  - No handshake -> hold.
- flush=1: next state EMPTY, in_ready=1.
  - Any input offered that cycle is dropped.
  - An output handshake in the flush cycle still completes and is counted.
  - out_valid=0 from the next cycle.
- decoded_count increments by 1 on each output handshake, including illegal entries, and wraps from all-ones to 0.
- Reset asserted mid-stream: immediate return to the reset values regardless of the handshake.

Test Plan:
- Reset, then 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> one cycle later out_valid=1, type I, immediate 0xFFFFFFFF, illegal=0, decoded_count 0->1.
- Back-to-back stream:
  - Stimulus: 0x00112623 (sw x1,12(x2)), 0xFE000EE3 (beq x0,x0,-4), 0x123452B7 (lui x5,0x12345), out_ready=1.
  - Response: S/0x0000000C, B/0xFFFFFFFC, U/0x12345000 on consecutive cycles; in_ready stays 1.
- Stall: hold out_ready=0 while sending 3 instructions.
  - Two are accepted, in_ready drops to 0 after the second, and out_* hold the first.
  - Release: the three emerge in order with no loss or duplication.
- 0x00000000 and 0x0000007F -> out_illegal=1, type R, immediate 0; each still increments decoded_count.
- flush while FULL with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the dropped input never appears; the count is unchanged unless a handshake occurred in the flush cycle.
- Preload decoded_count to 0xFFFFFFFF via force, complete one transfer -> count reads 0; assert reset_n=0 mid-stall -> outputs and count cleared without waiting for a clock edge.
